// File: rtl/mod_counter_if.sv
// mod_counter_if -- control/status bundle for mod_counter.
//   master: drives en, up, sat, load, load_val, clr_ovf; observes count, tc, ovf
//   slave : the counter itself
// Parameter WIDTH must match the WIDTH of the attached mod_counter.
interface mod_counter_if #(
  parameter int WIDTH = 5
) ();
  logic             en;        // count enable
  logic             up;        // 1 = increment, 0 = decrement
  logic             sat;       // 1 = saturate at bounds, 0 = wrap
  logic             load;      // synchronous load strobe
  logic [WIDTH-1:0] load_val;  // value to load (clamped to MAX)
  logic             clr_ovf;   // clear sticky overflow
  logic [WIDTH-1:0] count;     // registered count
  logic             tc;        // registered terminal-count pulse
  logic             ovf;       // registered sticky overflow

  modport master (
    output en, up, sat, load, load_val, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, sat, load, load_val, clr_ovf,
    output count, tc, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// mod_counter -- up/down modulo counter with wrap/saturate, load, terminal-count
// pulse and sticky overflow flag.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mod_counter_if.slave (en, up, sat, load, load_val, clr_ovf in;
//           count, tc, ovf out, all outputs registered)
// Parameters: WIDTH (bits), MAX (terminal count, 1..2**WIDTH-1),
//             PRESCALE (2..256, only used with the prescaler compiled in).
// Configuration macro: MOD_COUNTER_PRESCALE_EN compiles in an en-gated
// prescaler; without it every cycle with en=1 is a tick.
module mod_counter #(
  parameter int WIDTH    = 5,
  parameter int MAX      = 2**WIDTH-1,
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mod_counter_if.slave bus
);

  // Elaboration-time parameter range checks.
  if (MAX < 1 || MAX > 2**WIDTH-1) begin : g_bad_max
    $error("mod_counter: MAX out of range 1..2**WIDTH-1");
  end
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("mod_counter: PRESCALE out of range 2..256");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_clamped;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE-1);

  logic [PW-1:0] r_pre;

  // Tick fires on the edge where the prescaler wraps back to 0.
  assign w_tick = bus.en && (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (bus.load) begin
      r_pre <= '0;
    end else if (bus.en) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end
`else
  assign w_tick = bus.en;
`endif

  always_comb begin
    w_at_max       = (r_count == MAXV);
    w_at_zero      = (r_count == '0);
    w_load_clamped = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    // A boundary only counts when the tick is not overridden by load.
    w_boundary     = w_tick && !bus.load && (bus.up ? w_at_max : w_at_zero);
    w_next         = r_count;
    if (bus.up) begin
      if (w_at_max) w_next = bus.sat ? MAXV : '0;
      else          w_next = r_count + WIDTH'(1);
    end else begin
      if (w_at_zero) w_next = bus.sat ? '0 : MAXV;
      else           w_next = r_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.load) begin
        r_count <= w_load_clamped;
      end else if (w_tick) begin
        r_count <= w_next;
      end
      r_tc <= w_boundary;
      // Set wins over clear when both land on the same edge.
      if (w_boundary)       r_ovf <= 1'b1;
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter -- directed bench for mod_counter.
// DUT a: WIDTH=5, MAX=31. DUT b: WIDTH=5, MAX=9.
// Define MOD_COUNTER_PRESCALE_EN on both RTL and bench to exercise the prescaler.
module tb_mod_counter;

  logic clk;
  logic rst_n;
  int unsigned n_vec;
  int unsigned n_err;

  mod_counter_if #(.WIDTH(5)) if_a ();
  mod_counter_if #(.WIDTH(5)) if_b ();

  mod_counter #(.WIDTH(5), .MAX(31), .PRESCALE(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  mod_counter #(.WIDTH(5), .MAX(9), .PRESCALE(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int c, input int t, input int o);
    check({tag, ".count"}, 32'(if_a.count), 32'(c));
    check({tag, ".tc"},    32'(if_a.tc),    32'(t));
    check({tag, ".ovf"},   32'(if_a.ovf),   32'(o));
  endtask

  task automatic chk_b(input string tag, input int c, input int t, input int o);
    check({tag, ".count"}, 32'(if_b.count), 32'(c));
    check({tag, ".tc"},    32'(if_b.tc),    32'(t));
    check({tag, ".ovf"},   32'(if_b.ovf),   32'(o));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {if_a.en, if_a.up, if_a.sat, if_a.load, if_a.clr_ovf} = '0;
    {if_b.en, if_b.up, if_b.sat, if_b.load, if_b.clr_ovf} = '0;
    if_a.load_val = '0;
    if_b.load_val = '0;
    step();
    step();
    chk_a("rst_a", 0, 0, 0);
    chk_b("rst_b", 0, 0, 0);
    rst_n = 1'b1;

`ifndef MOD_COUNTER_PRESCALE_EN
    // Free-running up/wrap for 33 edges.
    if_a.up = 1'b1; if_a.en = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      chk_a($sformatf("upwrap%0d", i), i % 32, (i == 32) ? 1 : 0, (i >= 32) ? 1 : 0);
    end
    if_a.en = 1'b0;
    step();
    chk_a("hold", 1, 0, 1);

    // Set and clear on the same edge: set wins; clear alone next edge.
    if_a.load = 1'b1; if_a.load_val = 5'd31;
    step();
    chk_a("ld31", 31, 0, 1);
    if_a.load = 1'b0; if_a.en = 1'b1; if_a.clr_ovf = 1'b1;
    step();
    chk_a("set_clr", 0, 1, 1);
    if_a.en = 1'b0;
    step();
    chk_a("clr_only", 0, 0, 0);
    if_a.clr_ovf = 1'b0;

    // Down wrap from 0.
    if_a.up = 1'b0; if_a.en = 1'b1;
    step();
    chk_a("dnwrap", 31, 1, 1);
    if_a.en = 1'b0;

    // MAX=9, saturating down from 2.
    if_b.sat = 1'b1; if_b.up = 1'b0; if_b.load = 1'b1; if_b.load_val = 5'd2;
    step();
    chk_b("b_ld2", 2, 0, 0);
    if_b.load = 1'b0; if_b.en = 1'b1;
    step(); chk_b("b_dn1", 1, 0, 0);
    step(); chk_b("b_dn0", 0, 0, 0);
    step(); chk_b("b_sat0a", 0, 1, 1);
    step(); chk_b("b_sat0b", 0, 1, 1);
    if_b.en = 1'b0;
    step(); chk_b("b_idle", 0, 0, 1);

    // Load above MAX clamps; load beats a boundary tick.
    if_b.load = 1'b1; if_b.load_val = 5'd20; if_b.clr_ovf = 1'b1;
    step(); chk_b("b_clamp", 9, 0, 0);
    if_b.clr_ovf = 1'b0; if_b.up = 1'b1; if_b.en = 1'b1; if_b.load_val = 5'd3;
    step(); chk_b("b_ld_vs_tick", 3, 0, 0);

    // Saturate up at MAX, then wrap once sat drops.
    if_b.en = 1'b0; if_b.load_val = 5'd9;
    step(); chk_b("b_ld9", 9, 0, 0);
    if_b.load = 1'b0; if_b.en = 1'b1; if_b.sat = 1'b1;
    step(); chk_b("b_satup", 9, 1, 1);
    if_b.sat = 1'b0;
    step(); chk_b("b_wrapup", 0, 1, 1);
    step(); chk_b("b_up1", 1, 0, 1);

    // Reset overrides load and en.
    if_b.load = 1'b1;
    rst_n = 1'b0;
    step();
    chk_b("b_rst", 0, 0, 0);
    rst_n = 1'b1;
    if_b.load = 1'b0; if_b.en = 1'b0;
`else
    // Prescaled up count: one increment every 4th enabled edge.
    if_a.up = 1'b1; if_a.en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("pre%0d", i), 32'(if_a.count), 32'(i / 4));
    end
    step(); check("pre_mid", 32'(if_a.count), 32'd2);
    if_a.en = 1'b0;
    step(); check("pre_stall1", 32'(if_a.count), 32'd2);
    step(); check("pre_stall2", 32'(if_a.count), 32'd2);
    if_a.en = 1'b1;
    step(); check("pre_res2", 32'(if_a.count), 32'd2);
    step(); check("pre_res3", 32'(if_a.count), 32'd2);
    step(); check("pre_tick", 32'(if_a.count), 32'd3);

    // Load restarts the prescaler.
    step();
    if_a.load = 1'b1; if_a.load_val = 5'd7;
    step(); check("pre_ld", 32'(if_a.count), 32'd7);
    if_a.load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("pre_ld%0d", i), 32'(if_a.count), (i == 4) ? 32'd8 : 32'd7);
    end

    // Reset mid-period: full prescale period afterwards.
    step();
    rst_n = 1'b0;
    step(); chk_a("pre_rst", 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("pre_post%0d", i), 32'(if_a.count), (i == 4) ? 32'd1 : 32'd0);
    end
    if_a.en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
